// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port data SRAM between the exec LSU (r0) and a debug/loader port (r1).
// Optional SRAM_ARB_LOCK_EN adds per-requester lock inputs that pin the grant for read-modify-write sequences.
module sram_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_req_valid,
  output logic            r0_req_ready,
  input  logic            r0_we,
  input  logic [AW-1:0]   r0_addr,
  input  logic [DW-1:0]   r0_wdata,
  input  logic [DW/8-1:0] r0_wstrb,
  output logic            r0_rsp_valid,
  output logic [DW-1:0]   r0_rdata,
  input  logic            r1_req_valid,
  output logic            r1_req_ready,
  input  logic            r1_we,
  input  logic [AW-1:0]   r1_addr,
  input  logic [DW-1:0]   r1_wdata,
  input  logic [DW/8-1:0] r1_wstrb,
  output logic            r1_rsp_valid,
  output logic [DW-1:0]   r1_rdata,
`ifdef SRAM_ARB_LOCK_EN
  input  logic            r0_lock,
  input  logic            r1_lock,
`endif
  output logic            sram_en,
  output logic            sram_we,
  output logic [DW/8-1:0] sram_wstrb,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata
);

  logic last_grant;
  logic rsp_pend;
  logic rsp_owner;
  logic rsp_read;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

`ifdef SRAM_ARB_LOCK_EN
  logic locked;
  logic lock_owner;

  // A held lock hides the other requester entirely, even while the owner is idle.
  assign elig0 = r0_req_valid && !(locked && lock_owner);
  assign elig1 = r1_req_valid && !(locked && !lock_owner);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked     <= 1'b0;
      lock_owner <= 1'b0;
    end else if (grant0) begin
      if (r0_lock) begin
        locked     <= 1'b1;
        lock_owner <= 1'b0;
      end else if (locked && !lock_owner) begin
        locked <= 1'b0;
      end
    end else if (grant1) begin
      if (r1_lock) begin
        locked     <= 1'b1;
        lock_owner <= 1'b1;
      end else if (locked && lock_owner) begin
        locked <= 1'b0;
      end
    end
  end
`else
  assign elig0 = r0_req_valid;
  assign elig1 = r1_req_valid;
`endif

  // Ready is forced low during reset so nothing is accepted while rst is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign r0_req_ready = grant0;
  assign r1_req_ready = grant1;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_wstrb = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant0) begin
      sram_en    = 1'b1;
      sram_we    = r0_we;
      sram_wstrb = r0_wstrb;
      sram_addr  = r0_addr;
      sram_wdata = r0_wdata;
    end else if (grant1) begin
      sram_en    = 1'b1;
      sram_we    = r1_we;
      sram_wstrb = r1_wstrb;
      sram_addr  = r1_addr;
      sram_wdata = r1_wdata;
    end
  end

  // last_grant resets to 1 so r0 wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      rsp_pend   <= 1'b0;
      rsp_owner  <= 1'b0;
      rsp_read   <= 1'b0;
    end else begin
      rsp_pend <= sram_en;
      if (sram_en) begin
        last_grant <= grant1;
        rsp_owner  <= grant1;
        rsp_read   <= !sram_we;
      end
    end
  end

  assign r0_rsp_valid = rsp_pend && !rsp_owner;
  assign r1_rsp_valid = rsp_pend && rsp_owner;
  assign r0_rdata     = (r0_rsp_valid && rsp_read) ? sram_rdata : '0;
  assign r1_rdata     = (r1_rsp_valid && rsp_read) ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: SRAM environment model, per-cycle reference model, directed scenarios.
// Lock scenario is compiled only when SRAM_ARB_LOCK_EN is defined.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_req_valid, r0_req_ready, r0_we, r0_rsp_valid;
  logic [9:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic [3:0]  r0_wstrb;
  logic        r1_req_valid, r1_req_ready, r1_we, r1_rsp_valid;
  logic [9:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic [3:0]  r1_wstrb;
  logic        sram_en, sram_we;
  logic [3:0]  sram_wstrb;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
`ifdef SRAM_ARB_LOCK_EN
  logic        r0_lock, r1_lock;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] sram_mem [1024];
  logic [31:0] ref_mem  [1024];

  sram_port_arbiter #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
    .r0_rsp_valid(r0_rsp_valid), .r0_rdata(r0_rdata),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
    .r1_rsp_valid(r1_rsp_valid), .r1_rdata(r1_rdata),
`ifdef SRAM_ARB_LOCK_EN
    .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
    .sram_en(sram_en), .sram_we(sram_we), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] initWord(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 3) return 32'hAAAAAAAA;
    return 32'h5A000000 ^ (i * 32'h00010203);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // SRAM environment: one-cycle read latency, byte-strobed writes.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_wstrb);
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model state
  int          m_last;
  logic        m_rsp_v;
  int          m_rsp_owner;
  logic [31:0] m_rsp_data;
  int          e_win = -1;
`ifdef SRAM_ARB_LOCK_EN
  logic        m_locked;
  int          m_lock_owner;
`endif

  // Compare process: expected winner from the arbitration rules, checked every falling edge.
  always @(negedge clk) begin
    logic e0, e1;
    int   w;
    e0 = r0_req_valid;
    e1 = r1_req_valid;
`ifdef SRAM_ARB_LOCK_EN
    if (m_locked) begin
      if (m_lock_owner == 0) e1 = 1'b0;
      else                   e0 = 1'b0;
    end
`endif
    if (rst)             w = -1;
    else if (e0 && e1)   w = 1 - m_last;
    else if (e0)         w = 0;
    else if (e1)         w = 1;
    else                 w = -1;
    e_win = w;
    checkOutput("cmp_r0_ready", {31'd0, r0_req_ready}, {31'd0, w == 0});
    checkOutput("cmp_r1_ready", {31'd0, r1_req_ready}, {31'd0, w == 1});
    checkOutput("cmp_sram_en", {31'd0, sram_en}, {31'd0, w >= 0});
    checkOutput("cmp_sram_we", {31'd0, sram_we}, (w == 0) ? {31'd0, r0_we} : (w == 1) ? {31'd0, r1_we} : 32'd0);
    checkOutput("cmp_sram_addr", {22'd0, sram_addr}, (w == 0) ? {22'd0, r0_addr} : (w == 1) ? {22'd0, r1_addr} : 32'd0);
    checkOutput("cmp_sram_wdata", sram_wdata, (w == 0) ? r0_wdata : (w == 1) ? r1_wdata : 32'd0);
    checkOutput("cmp_sram_wstrb", {28'd0, sram_wstrb}, (w == 0) ? {28'd0, r0_wstrb} : (w == 1) ? {28'd0, r1_wstrb} : 32'd0);
    checkOutput("cmp_r0_rsp_valid", {31'd0, r0_rsp_valid}, {31'd0, !rst && m_rsp_v && m_rsp_owner == 0});
    checkOutput("cmp_r1_rsp_valid", {31'd0, r1_rsp_valid}, {31'd0, !rst && m_rsp_v && m_rsp_owner == 1});
    checkOutput("cmp_r0_rdata", r0_rdata, (!rst && m_rsp_v && m_rsp_owner == 0) ? m_rsp_data : 32'd0);
    checkOutput("cmp_r1_rdata", r1_rdata, (!rst && m_rsp_v && m_rsp_owner == 1) ? m_rsp_data : 32'd0);
  end

  // Model update: the winner's request is applied to the reference memory and queued as next cycle's response.
  always @(posedge clk or posedge rst) begin
    logic        we, lk;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    if (rst) begin
      m_last  <= 1;
      m_rsp_v <= 1'b0;
`ifdef SRAM_ARB_LOCK_EN
      m_locked     <= 1'b0;
      m_lock_owner <= 0;
`endif
    end else begin
      m_rsp_v <= (e_win >= 0);
      if (e_win >= 0) begin
        we = (e_win == 0) ? r0_we    : r1_we;
        a  = (e_win == 0) ? r0_addr  : r1_addr;
        d  = (e_win == 0) ? r0_wdata : r1_wdata;
        s  = (e_win == 0) ? r0_wstrb : r1_wstrb;
`ifdef SRAM_ARB_LOCK_EN
        lk = (e_win == 0) ? r0_lock : r1_lock;
        if (lk) begin
          m_locked     <= 1'b1;
          m_lock_owner <= e_win;
        end else if (m_locked && m_lock_owner == e_win) begin
          m_locked <= 1'b0;
        end
`else
        lk = 1'b0;
`endif
        m_last      <= e_win;
        m_rsp_owner <= e_win;
        m_rsp_data  <= we ? 32'd0 : ref_mem[a];
        if (we) ref_mem[a] <= merge(ref_mem[a], d, s);
      end
    end
  end

  task automatic applyStimulus(
    input logic v0, input logic we0, input logic [9:0] a0, input logic [31:0] d0, input logic [3:0] s0,
    input logic v1, input logic we1, input logic [9:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    @(posedge clk);
    #1;
    r0_req_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0; r0_wstrb = s0;
    r1_req_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1; r1_wstrb = s1;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    r0_req_valid = 0;
    r1_req_valid = 0;
    @(negedge clk);
    checkOutput("rst_sram_en", {31'd0, sram_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] b2b_exp [4];
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = initWord(i);
      ref_mem[i]  = initWord(i);
    end
    sram_rdata = 32'd0;
    rst = 1'b1;
    r0_req_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_wstrb = 0;
    r1_req_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_wstrb = 0;
`ifdef SRAM_ARB_LOCK_EN
    r0_lock = 0; r1_lock = 0;
`endif
    @(negedge clk);
    checkOutput("reset_r0_ready", {31'd0, r0_req_ready}, 32'd0);
    checkOutput("reset_r0_rsp", {31'd0, r0_rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single read of word 5
    applyStimulus(1, 0, 10'd5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s1_ready", {31'd0, r0_req_ready}, 32'd1);
    idle();
    checkOutput("s1_rsp_valid", {31'd0, r0_rsp_valid}, 32'd1);
    checkOutput("s1_rdata", r0_rdata, 32'hDEADBEEF);
    checkOutput("s1_r1_rsp", {31'd0, r1_rsp_valid}, 32'd0);

    // r1 partial write then readback
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 10'd3, 32'h12345678, 4'b0011);
    checkOutput("s2_wr_ready", {31'd0, r1_req_ready}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 10'd3, 0, 0);
    checkOutput("s2_wr_ack", {31'd0, r1_rsp_valid}, 32'd1);
    checkOutput("s2_wr_ack_rdata", r1_rdata, 32'd0);
    idle();
    checkOutput("s2_rd_data", r1_rdata, 32'hAAAA5678);

    // Zero-strobe write is still acked and changes nothing
    applyStimulus(1, 1, 10'd7, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 10'd7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s3_wr_ack", {31'd0, r0_rsp_valid}, 32'd1);
    idle();
    checkOutput("s3_rd_data", r0_rdata, initWord(7));

    // Contention from reset alternates, r0 first
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 10'(10 + i), 0, 0, 1, 0, 10'(20 + i), 0, 0);
      checkOutput("cont_r0_ready", {31'd0, r0_req_ready}, {31'd0, (i % 2) == 0});
      checkOutput("cont_r1_ready", {31'd0, r1_req_ready}, {31'd0, (i % 2) == 1});
      if (i > 0) checkOutput("cont_r0_rsp", {31'd0, r0_rsp_valid}, {31'd0, ((i - 1) % 2) == 0});
    end
    idle();
    checkOutput("cont_last_rsp", {31'd0, r1_rsp_valid}, 32'd1);
    checkOutput("cont_last_data", r1_rdata, initWord(25));

    // Back-to-back reads, no bubbles
    b2b_exp[0] = initWord(0);
    b2b_exp[1] = initWord(1);
    b2b_exp[2] = initWord(2);
    b2b_exp[3] = 32'hAAAA5678;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 10'(k), 0, 0, 0, 0, 0, 0, 0);
      checkOutput("b2b_ready", {31'd0, r0_req_ready}, 32'd1);
      if (k > 0) checkOutput("b2b_rdata", r0_rdata, b2b_exp[k - 1]);
    end
    idle();
    checkOutput("b2b_last_rsp", {31'd0, r0_rsp_valid}, 32'd1);
    checkOutput("b2b_last_rdata", r0_rdata, b2b_exp[3]);

    // Reset while a response is in flight
    applyStimulus(1, 0, 10'd5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mid_ready", {31'd0, r0_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready", {31'd0, r0_req_ready}, 32'd0);
    checkOutput("mid_rst_en", {31'd0, sram_en}, 32'd0);
    checkOutput("mid_rst_rsp", {31'd0, r0_rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0_req_valid = 0;
    @(negedge clk);
    checkOutput("mid_post_rsp", {31'd0, r0_rsp_valid}, 32'd0);
    idle();
    checkOutput("mid_post_rsp2", {31'd0, r0_rsp_valid}, 32'd0);

`ifdef SRAM_ARB_LOCK_EN
    // Lock held by r0 across an idle cycle until a write with lock clear
    doReset();
    r0_lock = 1;
    applyStimulus(1, 0, 10'd5, 0, 0, 1, 0, 10'd6, 0, 0);
    checkOutput("lock_grant_r0", {31'd0, r0_req_ready}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 10'd6, 0, 0);
    checkOutput("lock_r1_blocked", {31'd0, r1_req_ready}, 32'd0);
    applyStimulus(1, 0, 10'd5, 0, 0, 1, 0, 10'd6, 0, 0);
    checkOutput("lock_r0_again", {31'd0, r0_req_ready}, 32'd1);
    checkOutput("lock_r1_still", {31'd0, r1_req_ready}, 32'd0);
    r0_lock = 0;
    applyStimulus(1, 1, 10'd5, 32'h0BADF00D, 4'b1111, 1, 0, 10'd6, 0, 0);
    checkOutput("lock_release_wr", {31'd0, r0_req_ready}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 10'd6, 0, 0);
    checkOutput("lock_r1_granted", {31'd0, r1_req_ready}, 32'd1);
    idle();
`endif

    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
